regfile_wr_arbiter: RTL and testbench
=====================================

# regfile_wr_arbiter

Shares the register file's single write port (write enable, 5-bit write address, DATA_WIDTH write data) between two writeback sources: the execute stage (single-cycle results) and the memory controller (load returns). Execute results have default priority. Load returns are held in a small FIFO and are guaranteed service by a starvation counter. The block also exports a pending-write mask so the issue logic can stall on registers with an outstanding load.

## Interface
Parameters:
- DATA_WIDTH, 32: register data width.
- MEM_FIFO_DEPTH, 2: load-return FIFO entries; power of two, at least 2.
- STARVE_LIMIT, 4: consecutive lost arbitration cycles after which the memory path wins; at least 1.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  reset, synchronous, active-high.
- ex_valid  in  1  execute result valid.
- ex_ready  out  1  execute result accepted this cycle (combinational).
- ex_rd  in  5  execute destination register.
- ex_wd  in  DATA_WIDTH  execute result data.
- mem_valid  in  1  load return valid.
- mem_ready  out  1  FIFO not full (registered-state derived).
- mem_rd  in  5  load destination register.
- mem_wd  in  DATA_WIDTH  load data.
- rf_we  out  1  register file write enable (registered).
- rf_waddr  out  5  register file write address (registered).
- rf_wdata  out  DATA_WIDTH  register file write data (registered).
- pending  out  32  bit r set while a FIFO entry targets register r; bit 0 always 0.

## Operation
- Handshakes: a transfer occurs when valid and ready are both high at the rising edge. Once raised, valid must hold, with stable payload, until the transfer.
- Memory path: mem_ready = !fifo_full. There is no pass-through when full, and push-when-full cannot occur.
- Arbitration, each cycle:
  - The candidates are ex_valid and fifo_nonempty.
  - If starve_cnt == STARVE_LIMIT and the FIFO is non-empty: grant MEM, ex_ready = 0.
  - Otherwise, if ex_valid: grant EX.
  - Otherwise, if the FIFO is non-empty: grant MEM.
  - Otherwise: grant NONE.
- ex_ready = (grant == EX).
- A MEM grant pops the FIFO head at the edge.
- starve_cnt:
  - Resets to 0 on a MEM grant or when the FIFO is empty.
  - Increments when the FIFO is non-empty and EX is granted.
  - Saturates at STARVE_LIMIT.
- Output register:
  - On a grant, rf_waddr and rf_wdata load the winner's rd and data; rf_we = 1 only if rd != 0.
  - With no grant, rf_we = 0; waddr and wdata hold their previous values.
- Writes to x0 complete the handshake (and pop the FIFO) but never assert rf_we.
- pending: OR over valid FIFO entries of one-hot(rd), with bit 0 masked. It is combinational from FIFO state, so it rises the cycle after the push and clears the cycle after the pop.
- Ordering:
  - Within the memory path: FIFO order.
  - Between paths: no ordering guarantee. Issue logic must not launch an execute write to a register whose pending bit is set.
- Simultaneous FIFO push and pop: allowed at any occupancy below full; occupancy is unchanged.

## Timing
- Reset (rst high at an edge), state after that edge:
  - FIFO empty, starve_cnt = 0.
  - rf_we = 0, rf_waddr = 0, rf_wdata = 0, pending = 0.
- While rst is high: ex_ready = 0 and mem_ready = 0.
- Reset mid-operation discards all FIFO contents and any write not yet presented on rf_we.
- Execute latency: accept at edge N; rf_we is high during cycle N+1; the register file captures at the end of cycle N+1.
- Memory latency: push at edge N; earliest grant in cycle N+1; rf_we is high in cycle N+2.
- Throughput: one register-file write per cycle maximum.
- Worst-case wait for the FIFO head under continuous execute traffic: STARVE_LIMIT cycles, then granted.
- FIFO pointers wrap modulo MEM_FIFO_DEPTH; full/empty uses an extra pointer wrap bit.

## Structure
- Package regfile_arb_pkg:
  - REG_ADDR_W = 5, NUM_REGS = 32.
  - Grant encoding GNT_NONE = 2'd0, GNT_EX = 2'd1, GNT_MEM = 2'd2.
- Sub-module wb_fifo: synchronous FIFO of {rd, data}.
  - Parameterised depth.
  - Exposes its entry valid bits and rd fields for the pending mask.
- The arbiter, starvation counter and output register live in the top module.

## Test plan
- Reset: drive rst high for 2 cycles with both valids high -> both readies 0, rf_we 0, pending 0; after rst falls, ex_ready = 1 in the first cycle.
- Single writes:
  - Stimulus: ex (rd=5, 0xDEADBEEF) accepted at edge N -> rf_we = 1, waddr = 5, wdata = 0xDEADBEEF in cycle N+1 only.
  - Stimulus: mem (rd=7, 0x1234) pushed -> pending[7] = 1 until the pop, then rf_we in the cycle after the pop.
- Starvation: ex_valid held high continuously, one mem entry (rd=9) -> ex wins 4 cycles, ex_ready = 0 on the 5th, 0x…(rd 9) written next cycle, starve_cnt back to 0.
- FIFO full: 3 back-to-back mem returns while ex saturates -> mem_ready = 0 after 2 pushes; the 3rd is held until a pop; order rd 1, 2, 3 preserved at rf_waddr.
- x0 writes: ex rd=0 and mem rd=0 -> handshakes complete, FIFO pops, rf_we never asserted, pending[0] never set.
- Reset mid-operation: FIFO holding 2 entries, rst pulsed for 1 cycle -> pending = 0, mem_ready = 1 after release, no rf_we for the discarded entries.

Source files
------------

// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared widths, grant encoding and a one-hot helper for the regfile write arbiter.
// No logic of its own.
package regfile_arb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_EX   = 2'd1,
    GNT_MEM  = 2'd2
  } gnt_e;

  function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
    logic [NUM_REGS-1:0] oh;
    oh     = '0;
    oh[rd] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/regfile_wr_arbiter_wb_fifo.sv
// Load-return FIFO of {rd, data}; pushed entry is visible at the head the next cycle.
// Caller must not push when full_o or pop when empty_o; per-entry valid/rd feed the pending mask.
module wb_fifo
  import regfile_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                push_i,
  input  logic [REG_ADDR_W-1:0]               push_rd_i,
  input  logic [DATA_WIDTH-1:0]               push_wd_i,
  input  logic                                pop_i,
  output logic                                full_o,
  output logic                                empty_o,
  output logic [REG_ADDR_W-1:0]               head_rd_o,
  output logic [DATA_WIDTH-1:0]               head_wd_o,
  output logic [DEPTH-1:0]                    ent_vld_o,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]    ent_rd_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]                     wr_ptr_q, rd_ptr_q;
  logic [DEPTH-1:0]                vld_q;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] rd_mem_q;
  logic [DATA_WIDTH-1:0]           wd_mem_q [DEPTH];

  // The extra MSB of each pointer separates the full and empty cases.
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_rd_o = rd_mem_q[rd_ptr_q[AW-1:0]];
  assign head_wd_o = wd_mem_q[rd_ptr_q[AW-1:0]];
  assign ent_vld_o = vld_q;
  assign ent_rd_o  = rd_mem_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      vld_q    <= '0;
    end else begin
      if (pop_i) begin
        rd_ptr_q                  <= rd_ptr_q + 1'b1;
        vld_q[rd_ptr_q[AW-1:0]]   <= 1'b0;
      end
      if (push_i) begin
        wr_ptr_q                  <= wr_ptr_q + 1'b1;
        vld_q[wr_ptr_q[AW-1:0]]   <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) begin
      rd_mem_q[wr_ptr_q[AW-1:0]] <= push_rd_i;
      wd_mem_q[wr_ptr_q[AW-1:0]] <= push_wd_i;
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the regfile write port between execute results and buffered load returns.
// EX: 1 cycle to rf_we; MEM: >=2 cycles; ex_ready is combinational, mem_ready = FIFO not full.
module regfile_wr_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_FIFO_DEPTH = 2,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ex_valid_i,
  output logic                  ex_ready_o,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic [DATA_WIDTH-1:0] ex_wd_i,
  input  logic                  mem_valid_i,
  output logic                  mem_ready_o,
  input  logic [REG_ADDR_W-1:0] mem_rd_i,
  input  logic [DATA_WIDTH-1:0] mem_wd_i,
  output logic                  rf_we_o,
  output logic [REG_ADDR_W-1:0] rf_waddr_o,
  output logic [DATA_WIDTH-1:0] rf_wdata_o,
  output logic [NUM_REGS-1:0]   pending_o
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic                                     fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [REG_ADDR_W-1:0]                    head_rd;
  logic [DATA_WIDTH-1:0]                    head_wd;
  logic [MEM_FIFO_DEPTH-1:0]                ent_vld;
  logic [MEM_FIFO_DEPTH-1:0][REG_ADDR_W-1:0] ent_rd;

  gnt_e                  gnt;
  logic [CW-1:0]         starve_q, starve_d;
  logic                  rf_we_q, rf_we_d;
  logic [REG_ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;

  assign mem_ready_o = !rst_i && !fifo_full;
  assign fifo_push   = mem_valid_i && mem_ready_o;
  assign fifo_pop    = (gnt == GNT_MEM);
  assign ex_ready_o  = (gnt == GNT_EX);

  wb_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (MEM_FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (fifo_push),
    .push_rd_i (mem_rd_i),
    .push_wd_i (mem_wd_i),
    .pop_i     (fifo_pop),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .head_rd_o (head_rd),
    .head_wd_o (head_wd),
    .ent_vld_o (ent_vld),
    .ent_rd_o  (ent_rd)
  );

  always_comb begin
    gnt = GNT_NONE;
    if (!rst_i) begin
      if (starve_q == CW'(STARVE_LIMIT) && !fifo_empty) gnt = GNT_MEM;
      else if (ex_valid_i)                               gnt = GNT_EX;
      else if (!fifo_empty)                              gnt = GNT_MEM;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (gnt == GNT_MEM || fifo_empty)
      starve_d = '0;
    else if (gnt == GNT_EX && starve_q != CW'(STARVE_LIMIT))
      starve_d = starve_q + CW'(1);
  end

  // Address and data hold on idle cycles; only the enable drops.
  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    case (gnt)
      GNT_EX: begin
        rf_we_d    = (ex_rd_i != '0);
        rf_waddr_d = ex_rd_i;
        rf_wdata_d = ex_wd_i;
      end
      GNT_MEM: begin
        rf_we_d    = (head_rd != '0);
        rf_waddr_d = head_rd;
        rf_wdata_d = head_wd;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      starve_q   <= starve_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  always_comb begin
    pending_o = '0;
    for (int i = 0; i < MEM_FIFO_DEPTH; i++) begin
      if (ent_vld[i]) pending_o = pending_o | rd_onehot(ent_rd[i]);
    end
    pending_o[0] = 1'b0;
  end

  assign rf_we_o    = rf_we_q;
  assign rf_waddr_o = rf_waddr_q;
  assign rf_wdata_o = rf_wdata_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: queue-based reference model checked every negedge,
// directed scenarios with literal expectations, then a randomized phase.
module tb_regfile_wr_arbiter;

  localparam int DW    = 32;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst, ex_valid, ex_ready, mem_valid, mem_ready, rf_we;
  logic [4:0]    ex_rd, mem_rd, rf_waddr;
  logic [DW-1:0] ex_wd, mem_wd, rf_wdata;
  logic [31:0]   pending;

  always #5 clk = ~clk;

  regfile_wr_arbiter #(
    .DATA_WIDTH     (DW),
    .MEM_FIFO_DEPTH (DEPTH),
    .STARVE_LIMIT   (LIMIT)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .ex_valid_i  (ex_valid),
    .ex_ready_o  (ex_ready),
    .ex_rd_i     (ex_rd),
    .ex_wd_i     (ex_wd),
    .mem_valid_i (mem_valid),
    .mem_ready_o (mem_ready),
    .mem_rd_i    (mem_rd),
    .mem_wd_i    (mem_wd),
    .rf_we_o     (rf_we),
    .rf_waddr_o  (rf_waddr),
    .rf_wdata_o  (rf_wdata),
    .pending_o   (pending)
  );

  typedef struct packed {
    logic [4:0]    rd;
    logic [DW-1:0] wd;
  } item_t;

  // Reference model state: what the design must hold in the current cycle.
  item_t         mq[$];
  int            starve  = 0;
  logic          e_we    = 1'b0;
  logic [4:0]    e_waddr = '0;
  logic [DW-1:0] e_wdata = '0;

  int   n_cmp = 0;
  int   n_bad = 0;
  logic m_ex_rdy  = 1'b0;
  logic m_mem_rdy = 1'b0;

  // Literal expectations for the current cycle: bits we, waddr, wdata, exr, memr, pend.
  logic [5:0]    lit_en = '0;
  logic          lit_we, lit_exr, lit_memr;
  logic [4:0]    lit_waddr;
  logic [DW-1:0] lit_wdata;
  logic [31:0]   lit_pend;

  bit    mode_rand = 1'b0;
  bit    ex_auto   = 1'b0;
  item_t mem_src[$];

  function automatic int grant_of();
    if (rst) return 0;
    if (starve == LIMIT && mq.size() > 0) return 2;
    if (ex_valid) return 1;
    if (mq.size() > 0) return 2;
    return 0;
  endfunction

  function automatic logic [31:0] pend_of();
    logic [31:0] p;
    p = '0;
    foreach (mq[i]) p[mq[i].rd] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial forever begin
    int    g;
    bit    psh;
    item_t h;
    @(negedge clk);
    g = grant_of();
    m_ex_rdy  = (g == 1);
    m_mem_rdy = !rst && (mq.size() < DEPTH);
    chk("rf_we",     {31'b0, rf_we},     {31'b0, e_we});
    chk("rf_waddr",  {27'b0, rf_waddr},  {27'b0, e_waddr});
    chk("rf_wdata",  rf_wdata,           e_wdata);
    chk("ex_ready",  {31'b0, ex_ready},  {31'b0, m_ex_rdy});
    chk("mem_ready", {31'b0, mem_ready}, {31'b0, m_mem_rdy});
    chk("pending",   pending,            pend_of());
    if (lit_en[0]) chk("lit_we",    {31'b0, rf_we},     {31'b0, lit_we});
    if (lit_en[1]) chk("lit_waddr", {27'b0, rf_waddr},  {27'b0, lit_waddr});
    if (lit_en[2]) chk("lit_wdata", rf_wdata,           lit_wdata);
    if (lit_en[3]) chk("lit_exr",   {31'b0, ex_ready},  {31'b0, lit_exr});
    if (lit_en[4]) chk("lit_memr",  {31'b0, mem_ready}, {31'b0, lit_memr});
    if (lit_en[5]) chk("lit_pend",  pending,            lit_pend);
    // Advance the model across the coming rising edge.
    psh = mem_valid && m_mem_rdy;
    if (rst) begin
      mq.delete();
      starve  = 0;
      e_we    = 1'b0;
      e_waddr = '0;
      e_wdata = '0;
    end else begin
      if (g == 2 || mq.size() == 0) starve = 0;
      else if (g == 1 && starve < LIMIT) starve++;
      if (g == 1) begin
        e_we = (ex_rd != 0); e_waddr = ex_rd; e_wdata = ex_wd;
      end else if (g == 2) begin
        h = mq.pop_front();
        e_we = (h.rd != 0); e_waddr = h.rd; e_wdata = h.wd;
      end else begin
        e_we = 1'b0;
      end
      if (psh) mq.push_back({mem_rd, mem_wd});
    end
  end

  task automatic mem_present();
    mem_valid = (mem_src.size() > 0);
    if (mem_src.size() > 0) {mem_rd, mem_wd} = mem_src[0];
  endtask

  task automatic tick();
    bit ex_f, mem_f;
    @(posedge clk);
    #1;
    ex_f   = ex_valid && m_ex_rdy;
    mem_f  = mem_valid && m_mem_rdy;
    lit_en = '0;
    if (mode_rand) begin
      rst = ($urandom_range(0, 149) == 0);
      if (!ex_valid || ex_f) begin
        ex_valid = ($urandom_range(0, 3) != 0);
        ex_rd    = 5'($urandom);
        ex_wd    = $urandom;
      end
      if (!mem_valid || mem_f) begin
        mem_valid = ($urandom_range(0, 2) == 0);
        mem_rd    = 5'($urandom);
        mem_wd    = $urandom;
      end
    end else begin
      if (ex_f && ex_auto) begin
        ex_rd = 5'($urandom_range(10, 31));
        ex_wd = $urandom;
      end
      if (mem_f) void'(mem_src.pop_front());
      mem_present();
    end
  endtask

  task automatic lit_out(input logic we, input logic [4:0] a, input logic [DW-1:0] d);
    lit_we = we; lit_waddr = a; lit_wdata = d;
    lit_en[2:0] = 3'b111;
  endtask

  initial begin
    rst = 1'b1;
    ex_valid = 1'b1; ex_rd = 5'd5; ex_wd = 32'hDEADBEEF;
    mem_src.push_back({5'd3, 32'h33});
    mem_present();

    // Reset with both valids high.
    @(posedge clk); #1;
    lit_we = 1'b0; lit_exr = 1'b0; lit_memr = 1'b0; lit_pend = '0;
    lit_en = 6'b111001;
    tick();
    rst = 1'b0;
    mem_src.delete(); mem_present();
    lit_exr = 1'b1; lit_en[3] = 1'b1;
    tick();
    ex_valid = 1'b0;
    lit_out(1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    lit_we = 1'b0; lit_en[0] = 1'b1;

    // Single load return.
    mem_src.push_back({5'd7, 32'h1234}); mem_present();
    lit_memr = 1'b1; lit_en[4] = 1'b1;
    tick();
    lit_pend = 32'h80; lit_en[5] = 1'b1;
    tick();
    lit_out(1'b1, 5'd7, 32'h1234);
    lit_pend = '0; lit_en[5] = 1'b1;
    tick();
    lit_we = 1'b0; lit_en[0] = 1'b1;
    tick();

    // Starvation under continuous execute traffic.
    ex_auto = 1'b1; ex_valid = 1'b1; ex_rd = 5'd10; ex_wd = 32'hA0;
    mem_src.push_back({5'd9, 32'h99990009}); mem_present();
    lit_exr = 1'b1; lit_en[3] = 1'b1;
    tick();
    for (int k = 0; k < LIMIT; k++) begin
      lit_exr = 1'b1; lit_en[3] = 1'b1;
      tick();
    end
    lit_exr = 1'b0; lit_en[3] = 1'b1;
    tick();
    lit_out(1'b1, 5'd9, 32'h99990009);
    tick();

    // FIFO fills while execute saturates; load order must be kept.
    mem_src.push_back({5'd1, 32'h11});
    mem_src.push_back({5'd2, 32'h22});
    mem_src.push_back({5'd3, 32'h33});
    mem_present();
    lit_memr = 1'b1; lit_en[4] = 1'b1;
    tick();
    lit_memr = 1'b1; lit_en[4] = 1'b1;
    tick();
    lit_memr = 1'b0; lit_en[4] = 1'b1;
    tick();
    tick();
    tick();
    lit_exr = 1'b0; lit_en[3] = 1'b1;
    tick();
    lit_out(1'b1, 5'd1, 32'h11);
    lit_memr = 1'b1; lit_en[4] = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) tick();
    lit_out(1'b1, 5'd2, 32'h22);
    tick();
    for (int k = 0; k < 4; k++) tick();
    lit_out(1'b1, 5'd3, 32'h33);
    tick();
    ex_auto = 1'b0; ex_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick();

    // Writes to x0 from both paths.
    ex_valid = 1'b1; ex_rd = 5'd0; ex_wd = 32'h55;
    lit_exr = 1'b1; lit_en[3] = 1'b1;
    tick();
    ex_valid = 1'b0;
    lit_out(1'b0, 5'd0, 32'h55);
    mem_src.push_back({5'd0, 32'h77}); mem_present();
    lit_memr = 1'b1; lit_en[4] = 1'b1;
    tick();
    lit_pend = '0; lit_en[5] = 1'b1;
    tick();
    lit_out(1'b0, 5'd0, 32'h77);
    lit_memr = 1'b1; lit_en[4] = 1'b1;
    tick();

    // Reset while the FIFO holds two entries.
    ex_auto = 1'b1; ex_valid = 1'b1; ex_rd = 5'd12; ex_wd = 32'hC0;
    mem_src.push_back({5'd4, 32'h44});
    mem_src.push_back({5'd6, 32'h66});
    mem_present();
    tick();
    tick();
    lit_pend = 32'h50; lit_en[5] = 1'b1;
    rst = 1'b1; ex_auto = 1'b0; ex_valid = 1'b0;
    tick();
    rst = 1'b0;
    lit_pend = '0; lit_memr = 1'b1; lit_we = 1'b0; lit_en = 6'b110001;
    tick();
    lit_we = 1'b0; lit_en[0] = 1'b1;
    tick();

    // Randomized traffic including occasional resets.
    mode_rand = 1'b1;
    for (int k = 0; k < 3000; k++) tick();
    mode_rand = 1'b0;
    rst = 1'b0; ex_valid = 1'b0;
    mem_src.delete(); mem_present();
    for (int k = 0; k < 12; k++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
